// File: rtl/pipe_in_code_player_pkg.sv
// Shared definitions for the host pipe-in code player and the ADC capture path.
package pipe_in_code_player_pkg;

  localparam int PRECISION_DEFAULT = 10;
  localparam int PIPE_W            = 16;
  localparam int RATE_W            = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_PLAY  = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_in_code_player_fifo.sv
// Single-clock FIFO with registered read data and an explicit fill count.
// The read register resets to zero but survives a clear, so it can drive the played code directly.
module sync_fifo #(
  parameter int WIDTH      = 10,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clear,
  input  logic                  i_wr_en,
  input  logic [WIDTH-1:0]      i_wr_data,
  input  logic                  i_rd_en,
  output logic [WIDTH-1:0]      o_rd_data,
  output logic [DEPTH_LOG2:0]   o_fill,
  output logic                  o_empty,
  output logic                  o_full
);

  localparam int                DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FILL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_fill;
  logic [WIDTH-1:0]      r_rd_data;
  logic                  w_wr;
  logic                  w_rd;

  assign o_empty   = (r_fill == '0);
  assign o_full    = (r_fill == FILL_FULL);
  assign o_fill    = r_fill;
  assign o_rd_data = r_rd_data;

  // A simultaneous read frees a slot, so a write into a full buffer is still accepted.
  assign w_rd = i_rd_en && !i_clear && !o_empty;
  assign w_wr = i_wr_en && !i_clear && (!o_full || w_rd);

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_fill    <= '0;
      r_rd_data <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
      end
      if (w_rd) begin
        r_rd_ptr  <= r_rd_ptr + DEPTH_LOG2'(1);
        r_rd_data <= r_mem[r_rd_ptr];
      end
      if (w_wr && !w_rd) begin
        r_fill <= r_fill + (DEPTH_LOG2 + 1)'(1);
      end else if (w_rd && !w_wr) begin
        r_fill <= r_fill - (DEPTH_LOG2 + 1)'(1);
      end
    end
  end

endmodule

// File: rtl/pipe_in_code_player.sv
// Buffers host pipe-in codes and replays them at a programmable rate once enough are primed.
// Tracks dropped writes (overflow) and ticks that found nothing to play (underflow).
module pipe_in_code_player
  import pipe_in_code_player_pkg::*;
#(
  parameter int PRECISION  = PRECISION_DEFAULT,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pipe_write,
  input  logic [PIPE_W-1:0]     pipe_data,
  input  logic                  clear,
  input  logic                  enable,
  input  logic [DEPTH_LOG2:0]   start_level,
  input  logic [RATE_W-1:0]     rate_div,
  output logic [PRECISION-1:0]  code_out,
  output logic                  code_valid,
  output logic [DEPTH_LOG2:0]   fill_count,
  output logic                  overflow,
  output logic                  underflow,
  output logic [1:0]            state
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [RATE_W-1:0]   r_rate_cnt;
  logic                r_code_valid;
  logic                r_overflow;
  logic                r_underflow;

  logic                w_tick;
  logic                w_pop;
  logic                w_wr_req;
  logic                w_empty;
  logic                w_full;
  logic [DEPTH_LOG2:0] w_fill;

  if (PRECISION < PIPE_W) begin : g_unused_hi
    logic w_unused_hi;
    assign w_unused_hi = ^pipe_data[PIPE_W-1:PRECISION];
  end

  // The tick compares with >= so that lowering rate_div mid-period cannot strand the counter.
  assign w_tick   = !clear && enable && (r_state == ST_PLAY) && (r_rate_cnt >= rate_div);
  assign w_pop    = w_tick && !w_empty;
  assign w_wr_req = pipe_write && !clear;

  sync_fifo #(
    .WIDTH      (PRECISION),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (clear),
    .i_wr_en   (w_wr_req),
    .i_wr_data (pipe_data[PRECISION-1:0]),
    .i_rd_en   (w_pop),
    .o_rd_data (code_out),
    .o_fill    (w_fill),
    .o_empty   (w_empty),
    .o_full    (w_full)
  );

  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (enable) w_state_nxt = ST_PRIME;
        end
        ST_PRIME: begin
          if (!enable)                       w_state_nxt = ST_IDLE;
          else if (w_fill >= start_level)    w_state_nxt = ST_PLAY;
        end
        ST_PLAY: begin
          if (!enable) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rate_cnt <= '0;
    end else if (clear || (r_state != ST_PLAY)) begin
      r_rate_cnt <= '0;
    end else if (r_rate_cnt >= rate_div) begin
      r_rate_cnt <= '0;
    end else begin
      r_rate_cnt <= r_rate_cnt + 16'd1;
    end
  end

  // A write landing on an empty buffer during a tick is stored, never bypassed to the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_code_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else if (clear) begin
      r_code_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      r_code_valid <= w_pop;
      if (pipe_write && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
      if (w_tick && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign code_valid = r_code_valid;
  assign fill_count = w_fill;
  assign overflow   = r_overflow;
  assign underflow  = r_underflow;
  assign state      = r_state;

endmodule

// File: tb/tb_pipe_in_code_player.sv
// Bench for pipe_in_code_player: directed scenarios plus randomized traffic against a queue-based model.
module tb_pipe_in_code_player;

  localparam int PREC  = 10;
  localparam int DL    = 10;
  localparam int DEPTH = 1 << DL;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pipe_write;
  logic [15:0]   pipe_data;
  logic          clear;
  logic          enable;
  logic [DL:0]   start_level;
  logic [15:0]   rate_div;
  logic [PREC-1:0] code_out;
  logic          code_valid;
  logic [DL:0]   fill_count;
  logic          overflow;
  logic          underflow;
  logic [1:0]    state;

  int errors = 0;
  int checks = 0;

  pipe_in_code_player #(.PRECISION(PREC), .DEPTH_LOG2(DL)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pipe_write  (pipe_write),
    .pipe_data   (pipe_data),
    .clear       (clear),
    .enable      (enable),
    .start_level (start_level),
    .rate_div    (rate_div),
    .code_out    (code_out),
    .code_valid  (code_valid),
    .fill_count  (fill_count),
    .overflow    (overflow),
    .underflow   (underflow),
    .state       (state)
  );

  always #5 clk = ~clk;

  // Behavioural model: a queue of buffered codes plus playback bookkeeping.
  logic [PREC-1:0] mq[$];
  logic [PREC-1:0] m_code;
  bit m_vld, m_ovf, m_unf;
  int m_st, m_cnt, m_sz;
  bit m_tk, m_pp;

  task automatic model_reset();
    mq.delete();
    m_code = '0; m_vld = 0; m_ovf = 0; m_unf = 0; m_st = 0; m_cnt = 0;
  endtask

  always @(posedge clk) begin
    if (rst_n) begin
      if (clear) begin
        mq.delete();
        m_vld = 0; m_ovf = 0; m_unf = 0; m_st = 0; m_cnt = 0;
      end else begin
        m_sz = mq.size();
        m_tk = (m_st == 2) && enable && (m_cnt == int'(rate_div));
        m_pp = m_tk && (m_sz > 0);
        m_vld = m_pp;
        if (m_pp) m_code = mq.pop_front();
        if (m_tk && m_sz == 0) m_unf = 1;
        if (pipe_write) begin
          if (m_sz < DEPTH || m_pp) mq.push_back(pipe_data[PREC-1:0]);
          else m_ovf = 1;
        end
        if (m_st == 2) m_cnt = (m_cnt == int'(rate_div)) ? 0 : m_cnt + 1;
        else m_cnt = 0;
        case (m_st)
          0: if (enable) m_st = 1;
          1: if (!enable) m_st = 0; else if (m_sz >= int'(start_level)) m_st = 2;
          default: if (!enable) m_st = 0;
        endcase
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; pipe_write = 0; clear = 0; enable = 0;
    pipe_data = '0; start_level = '0; rate_div = '0;
    model_reset();
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; pipe_write = 0; clear = 0; enable = 0;
    pipe_data = '0; start_level = '0; rate_div = '0;
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    checks += 6;
    if (code_out !== '0)   begin errors++; $display("FAIL reset_code: got %0h expected 0", code_out); end
    if (code_valid !== 0)  begin errors++; $display("FAIL reset_valid: got %0b expected 0", code_valid); end
    if (fill_count !== '0) begin errors++; $display("FAIL reset_fill: got %0d expected 0", fill_count); end
    if (overflow !== 0)    begin errors++; $display("FAIL reset_ovf: got %0b expected 0", overflow); end
    if (underflow !== 0)   begin errors++; $display("FAIL reset_unf: got %0b expected 0", underflow); end
    if (state !== 2'd0)    begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_basic_play();
    bit saw_prime = 0, saw_play = 0;
    int npulse = 0, last = -1, first = -1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      pipe_write = 1; pipe_data = 16'(i + 1); step();
    end
    pipe_write = 0;
    checks++;
    if (fill_count !== 11'd4) begin errors++; $display("FAIL basic_fill: got %0d expected 4", fill_count); end
    start_level = 11'd4; rate_div = 16'd2; enable = 1;
    for (int c = 0; c < 30; c++) begin
      step();
      if (state === 2'd1) saw_prime = 1;
      if (state === 2'd2) saw_play = 1;
      checks++;
      if (code_valid !== m_vld) begin errors++; $display("FAIL basic_valid c=%0d: got %0b expected %0b", c, code_valid, m_vld); end
      if (code_valid === 1'b1) begin
        checks++;
        if (code_out !== 10'(npulse + 1) || code_out !== m_code)
          begin errors++; $display("FAIL basic_code #%0d: got %0h expected %0h", npulse, code_out, npulse + 1); end
        if (npulse == 0) first = c;
        else begin
          checks++;
          if (c - last != 3) begin errors++; $display("FAIL basic_gap: got %0d expected 3", c - last); end
        end
        last = c;
        npulse++;
      end
    end
    checks += 4;
    if (!saw_prime)   begin errors++; $display("FAIL basic_prime: got 0 expected 1"); end
    if (!saw_play)    begin errors++; $display("FAIL basic_play: got 0 expected 1"); end
    if (npulse != 4)  begin errors++; $display("FAIL basic_count: got %0d expected 4", npulse); end
    if (first != 4)   begin errors++; $display("FAIL basic_latency: got %0d expected 4", first); end
    enable = 0; step();
  endtask

  task automatic test_rate0_underflow();
    int npulse = 0, first = -1;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      pipe_write = 1; pipe_data = 16'(i + 1); step();
    end
    pipe_write = 0;
    start_level = 11'd8; rate_div = 16'd0; enable = 1;
    for (int c = 0; c < 25; c++) begin
      step();
      if (code_valid === 1'b1) begin
        checks++;
        if (npulse == 0) first = c;
        if (c != first + npulse || code_out !== 10'(npulse + 1))
          begin errors++; $display("FAIL r0_pulse #%0d: got code %0h at %0d expected %0h at %0d", npulse, code_out, c, npulse + 1, first + npulse); end
        npulse++;
      end
    end
    checks += 4;
    if (npulse != 8)        begin errors++; $display("FAIL r0_count: got %0d expected 8", npulse); end
    if (underflow !== 1'b1) begin errors++; $display("FAIL r0_underflow: got %0b expected 1", underflow); end
    if (code_out !== 10'd8) begin errors++; $display("FAIL r0_hold: got %0h expected 8", code_out); end
    if (state !== 2'd2)     begin errors++; $display("FAIL r0_state: got %0d expected 2", state); end
    clear = 1; step(); clear = 0;
    checks += 3;
    if (underflow !== 1'b0) begin errors++; $display("FAIL r0_clear_unf: got %0b expected 0", underflow); end
    if (state !== 2'd0)     begin errors++; $display("FAIL r0_clear_state: got %0d expected 0", state); end
    if (code_out !== 10'd8) begin errors++; $display("FAIL r0_clear_hold: got %0h expected 8", code_out); end
    enable = 0; step();
  endtask

  task automatic test_overflow();
    int npulse = 0;
    do_reset();
    for (int i = 0; i <= DEPTH; i++) begin
      pipe_write = 1;
      pipe_data = (i == DEPTH) ? 16'h03AB : 16'(i + 1);
      step();
    end
    pipe_write = 0;
    checks += 2;
    if (fill_count !== 11'd1024) begin errors++; $display("FAIL ovf_fill: got %0d expected 1024", fill_count); end
    if (overflow !== 1'b1)       begin errors++; $display("FAIL ovf_flag: got %0b expected 1", overflow); end
    start_level = 11'd1; rate_div = 16'd0; enable = 1;
    for (int c = 0; c < 1100; c++) begin
      step();
      if (code_valid === 1'b1) begin
        checks++;
        if (code_out !== 10'((npulse + 1) & 1023))
          begin errors++; $display("FAIL ovf_word #%0d: got %0h expected %0h", npulse, code_out, (npulse + 1) & 1023); end
        npulse++;
      end
    end
    checks += 2;
    if (npulse != DEPTH)   begin errors++; $display("FAIL ovf_count: got %0d expected 1024", npulse); end
    if (fill_count !== '0) begin errors++; $display("FAIL ovf_drain: got %0d expected 0", fill_count); end
    enable = 0; step();
  endtask

  task automatic test_full_stream();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      pipe_write = 1; pipe_data = 16'($urandom); step();
    end
    pipe_write = 0;
    start_level = 11'd1024; rate_div = 16'd0; enable = 1;
    for (int i = 0; i < 6 && state !== 2'd2; i++) step();
    checks++;
    if (state !== 2'd2) begin errors++; $display("FAIL full_enter_play: got %0d expected 2", state); end
    for (int c = 0; c < 64; c++) begin
      pipe_write = 1; pipe_data = 16'($urandom);
      step();
      checks += 4;
      if (fill_count !== 11'd1024) begin errors++; $display("FAIL full_fill c=%0d: got %0d expected 1024", c, fill_count); end
      if (overflow !== 1'b0)       begin errors++; $display("FAIL full_ovf c=%0d: got %0b expected 0", c, overflow); end
      if (code_valid !== 1'b1)     begin errors++; $display("FAIL full_valid c=%0d: got %0b expected 1", c, code_valid); end
      if (code_out !== m_code)     begin errors++; $display("FAIL full_code c=%0d: got %0h expected %0h", c, code_out, m_code); end
    end
    pipe_write = 0; enable = 0; step();
  endtask

  task automatic test_upper_bits();
    bit seen = 0;
    do_reset();
    pipe_write = 1; pipe_data = 16'hFC05; step(); pipe_write = 0;
    start_level = 11'd1; rate_div = 16'd0; enable = 1;
    for (int c = 0; c < 10 && !seen; c++) begin
      step();
      if (code_valid === 1'b1) seen = 1;
    end
    checks += 2;
    if (!seen) begin errors++; $display("FAIL upper_timeout: got no code_valid expected one"); end
    if (code_out !== 10'h005) begin errors++; $display("FAIL upper_code: got %0h expected 005", code_out); end
    enable = 0; step();
  endtask

  task automatic test_clear_and_reset();
    logic [PREC-1:0] saved;
    bit seen = 0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      pipe_write = 1; pipe_data = 16'(i + 16'h10); step();
    end
    pipe_write = 0;
    start_level = 11'd20; rate_div = 16'd3; enable = 1;
    for (int c = 0; c < 200 && !(fill_count === 11'd10 && state === 2'd2); c++) step();
    checks++;
    if (fill_count !== 11'd10) begin errors++; $display("FAIL clr_setup: got fill %0d expected 10", fill_count); end
    saved = code_out;
    clear = 1; pipe_write = 1; pipe_data = 16'h0155;
    step();
    clear = 0; pipe_write = 0;
    checks += 6;
    if (fill_count !== '0)  begin errors++; $display("FAIL clr_fill: got %0d expected 0", fill_count); end
    if (state !== 2'd0)     begin errors++; $display("FAIL clr_state: got %0d expected 0", state); end
    if (overflow !== 1'b0)  begin errors++; $display("FAIL clr_ovf: got %0b expected 0", overflow); end
    if (underflow !== 1'b0) begin errors++; $display("FAIL clr_unf: got %0b expected 0", underflow); end
    if (code_out !== saved) begin errors++; $display("FAIL clr_hold: got %0h expected %0h", code_out, saved); end
    if (code_valid !== 1'b0) begin errors++; $display("FAIL clr_valid: got %0b expected 0", code_valid); end
    start_level = 11'd1; rate_div = 16'd0;
    for (int i = 0; i < 3; i++) begin
      pipe_write = 1; pipe_data = 16'(16'h02A1 + i); step();
    end
    pipe_write = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (code_valid === 1'b1) seen = 1; else step();
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL rst_setup: got no code_valid expected one"); end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks += 3;
    if (code_out !== '0)   begin errors++; $display("FAIL rst_code: got %0h expected 0", code_out); end
    if (fill_count !== '0) begin errors++; $display("FAIL rst_fill: got %0d expected 0", fill_count); end
    if (state !== 2'd0)    begin errors++; $display("FAIL rst_state: got %0d expected 0", state); end
    enable = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_random();
    for (int seg = 0; seg < 4; seg++) begin
      clear = 1; pipe_write = 0; step(); clear = 0;
      rate_div = 16'($urandom_range(0, 3));
      start_level = 11'($urandom_range(0, 12));
      enable = 1;
      for (int c = 0; c < 300; c++) begin
        pipe_write = ($urandom_range(0, 9) < 6);
        pipe_data = 16'($urandom);
        if ($urandom_range(0, 49) == 0) enable = !enable;
        clear = ($urandom_range(0, 99) == 0);
        step();
        checks += 6;
        if (code_out !== m_code)          begin errors++; $display("FAIL rnd_code s%0d c%0d: got %0h expected %0h", seg, c, code_out, m_code); end
        if (code_valid !== m_vld)         begin errors++; $display("FAIL rnd_valid s%0d c%0d: got %0b expected %0b", seg, c, code_valid, m_vld); end
        if (fill_count !== 11'(mq.size())) begin errors++; $display("FAIL rnd_fill s%0d c%0d: got %0d expected %0d", seg, c, fill_count, mq.size()); end
        if (overflow !== m_ovf)           begin errors++; $display("FAIL rnd_ovf s%0d c%0d: got %0b expected %0b", seg, c, overflow, m_ovf); end
        if (underflow !== m_unf)          begin errors++; $display("FAIL rnd_unf s%0d c%0d: got %0b expected %0b", seg, c, underflow, m_unf); end
        if (state !== 2'(m_st))           begin errors++; $display("FAIL rnd_state s%0d c%0d: got %0d expected %0d", seg, c, state, m_st); end
      end
    end
    clear = 0; pipe_write = 0; enable = 0; step();
  endtask

  initial begin
    test_reset();
    test_basic_play();
    test_rate0_underflow();
    test_overflow();
    test_full_stream();
    test_upper_bits();
    test_clear_and_reset();
    do_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
